// File: rtl/hazard_unit.sv
// hazard_unit: pipeline hazard controller for the IF/ID and ID/EX registers.
// Detects load-use hazards against the instruction in EX and holds PC and IF/ID
// while ID/EX captures bubbles. The stall is stretched to LOAD_STALL_CYCLES by a
// small RUN/STALL FSM. A taken branch/jump squashes IF/ID and aborts any stall.
// Two wrapping counters report stall and flush activity.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   id_rs1/id_rs2         source registers of the ID instruction
//   id_use_rs1/rs2        ID instruction actually reads that source
//   ex_rd, ex_load        destination and load flag of the EX instruction
//   NextPCSrc             taken branch/jump resolved in EX
//   hazard_detection      ID/EX captures a bubble this cycle
//   pc_write, ifid_write  PC / IF/ID may update (0 = hold)
//   ifid_flush            IF/ID loads a NOP
//   stall_active          FSM is in STALL
//   stall_count           cycles with hazard_detection = 1
//   flush_count           cycles with NextPCSrc = 1
module hazard_unit #(
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned CNT_W             = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_load,
    input  logic             NextPCSrc,
    output logic             hazard_detection,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             stall_active,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic {StRun, StStall} state_e;

    // Remaining extra bubbles after the one issued in RUN.
    localparam logic [1:0] StallInit = 2'(LOAD_STALL_CYCLES - 1);
    localparam bit         MultiCycle = (LOAD_STALL_CYCLES > 1);

    state_e           state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;
    logic             load_use;

    // x0 is never a real dependency, so ex_rd == 0 cannot cause a hazard.
    assign load_use = ex_load && (ex_rd != 5'd0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));

    // State register and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StRun;
            cnt_q         <= 2'd0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    // Next-state logic. A redirect always wins: the ID instruction is wrong-path.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StRun: begin
                if (!NextPCSrc && load_use && MultiCycle) begin
                    state_d = StStall;
                    cnt_d   = StallInit;
                end
            end
            StStall: begin
                if (NextPCSrc) begin
                    state_d = StRun;
                    cnt_d   = 2'd0;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                    if (cnt_q == 2'd1) begin
                        state_d = StRun;
                    end
                end
            end
            default: begin
                state_d = StRun;
                cnt_d   = 2'd0;
            end
        endcase
    end

    // Output logic, combinational from inputs and current state.
    always_comb begin
        hazard_detection = 1'b0;
        pc_write         = 1'b1;
        ifid_write       = 1'b1;
        ifid_flush       = 1'b0;
        if (!rst) begin
            if (NextPCSrc) begin
                ifid_flush = 1'b1;
            end else if ((state_q == StStall) || load_use) begin
                hazard_detection = 1'b1;
                pc_write         = 1'b0;
                ifid_write       = 1'b0;
            end
        end
    end

    // Event counters wrap freely.
    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (hazard_detection) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
        if (NextPCSrc) begin
            flush_count_d = flush_count_q + CNT_W'(1);
        end
    end

    assign stall_active = (state_q == StStall);
    assign stall_count  = stall_count_q;
    assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: three instances with different stall lengths and counter
// widths share the same stimulus and are checked every cycle against a model
// that tracks the number of bubbles still owed per instance.
module tb_hazard_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_use_rs1, id_use_rs2, ex_load, NextPCSrc;

    logic [2:0]  hd_w, pw_w, iw_w, fl_w, sa_w;
    logic [31:0] sc_a, fc_a;
    logic [3:0]  sc_b, fc_b;
    logic [7:0]  sc_c, fc_c;
    logic [31:0] sc_w [3];
    logic [31:0] fc_w [3];

    int unsigned lsc [3] = '{1, 2, 3};
    int unsigned wid [3] = '{32, 4, 8};

    // Model state: bubbles still owed after the current cycle, event totals.
    int          rem [3];
    longint unsigned sc_m [3];
    longint unsigned fc_m [3];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_unit #(.LOAD_STALL_CYCLES(1), .CNT_W(32)) u_a (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_load(ex_load), .NextPCSrc(NextPCSrc), .hazard_detection(hd_w[0]),
        .pc_write(pw_w[0]), .ifid_write(iw_w[0]), .ifid_flush(fl_w[0]),
        .stall_active(sa_w[0]), .stall_count(sc_a), .flush_count(fc_a)
    );

    hazard_unit #(.LOAD_STALL_CYCLES(2), .CNT_W(4)) u_b (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_load(ex_load), .NextPCSrc(NextPCSrc), .hazard_detection(hd_w[1]),
        .pc_write(pw_w[1]), .ifid_write(iw_w[1]), .ifid_flush(fl_w[1]),
        .stall_active(sa_w[1]), .stall_count(sc_b), .flush_count(fc_b)
    );

    hazard_unit #(.LOAD_STALL_CYCLES(3), .CNT_W(8)) u_c (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_load(ex_load), .NextPCSrc(NextPCSrc), .hazard_detection(hd_w[2]),
        .pc_write(pw_w[2]), .ifid_write(iw_w[2]), .ifid_flush(fl_w[2]),
        .stall_active(sa_w[2]), .stall_count(sc_c), .flush_count(fc_c)
    );

    assign sc_w[0] = sc_a;
    assign fc_w[0] = fc_a;
    assign sc_w[1] = {28'd0, sc_b};
    assign fc_w[1] = {28'd0, fc_b};
    assign sc_w[2] = {24'd0, sc_c};
    assign fc_w[2] = {24'd0, fc_c};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_lu();
        bit m1, m2;
        m1 = id_use_rs1 && (id_rs1 == ex_rd);
        m2 = id_use_rs2 && (id_rs2 == ex_rd);
        return ex_load && (ex_rd != 0) && (m1 || m2);
    endfunction

    function automatic logic [31:0] wrap(input longint unsigned v, input int unsigned w);
        return 32'(v % (64'd1 << w));
    endfunction

    // Compare every instance against the model for the current inputs.
    task automatic check_all();
        bit lu, bubble;
        lu = model_lu();
        for (int i = 0; i < 3; i++) begin
            bubble = !rst && !NextPCSrc && ((rem[i] > 0) || lu);
            chk($sformatf("hd%0d", i), {31'd0, hd_w[i]}, {31'd0, bubble});
            chk($sformatf("pcw%0d", i), {31'd0, pw_w[i]}, {31'd0, !bubble});
            chk($sformatf("ifw%0d", i), {31'd0, iw_w[i]}, {31'd0, !bubble});
            chk($sformatf("fl%0d", i), {31'd0, fl_w[i]}, {31'd0, (!rst && NextPCSrc)});
            chk($sformatf("sa%0d", i), {31'd0, sa_w[i]}, {31'd0, (rem[i] > 0)});
            chk($sformatf("sc%0d", i), sc_w[i], wrap(sc_m[i], wid[i]));
            chk($sformatf("fc%0d", i), fc_w[i], wrap(fc_m[i], wid[i]));
        end
    endtask

    task automatic model_edge();
        bit lu;
        lu = model_lu();
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                rem[i]  = 0;
                sc_m[i] = 0;
                fc_m[i] = 0;
            end else if (NextPCSrc) begin
                rem[i] = 0;
                fc_m[i]++;
            end else if (rem[i] > 0) begin
                rem[i]--;
                sc_m[i]++;
            end else if (lu) begin
                rem[i] = int'(lsc[i]) - 1;
                sc_m[i]++;
            end
        end
    endtask

    // Check mid-cycle, then advance the model with the DUT at the edge.
    task automatic step();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        ex_load = 1'b0; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; NextPCSrc = 1'b0;
    endtask

    task automatic lu_rs2(input logic [4:0] r);
        ex_load = 1'b1; ex_rd = r; id_rs2 = r; id_use_rs2 = 1'b1;
        id_rs1 = 5'd0; id_use_rs1 = 1'b0; NextPCSrc = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rem[i] = 0; sc_m[i] = 0; fc_m[i] = 0;
        end
        // Reset held with a hazard present on the inputs.
        rst = 1'b1; idle();
        ex_load = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
        @(posedge clk);
        model_edge();
        #1;
        step();
        step();
        chk("rst_hd", {31'd0, hd_w[2]}, 32'd0);
        chk("rst_pcw", {31'd0, pw_w[2]}, 32'd1);
        chk("rst_sc", sc_w[2], 32'd0);
        chk("rst_sa", {31'd0, sa_w[2]}, 32'd0);

        // Single load-use pulse, then idle.
        rst = 1'b0; idle();
        step();
        lu_rs2(5'd7);
        step();
        idle();
        repeat (4) step();
        chk("lu_sc_a", sc_w[0], 32'd1);
        chk("lu_sc_b", sc_w[1], 32'd2);
        chk("lu_sc_c", sc_w[2], 32'd3);

        // ex_rd = 0 never stalls.
        lu_rs2(5'd0);
        step();
        idle();
        step();
        chk("x0_sc_c", sc_w[2], 32'd3);

        // Redirect and load-use together: only the flush counts.
        lu_rs2(5'd9);
        NextPCSrc = 1'b1;
        step();
        idle();
        step();
        chk("prio_sc_c", sc_w[2], 32'd3);
        chk("prio_fc_c", fc_w[2], 32'd1);

        // Abort a stall with a redirect in its first STALL cycle.
        lu_rs2(5'd3);
        step();
        idle();
        NextPCSrc = 1'b1;
        @(negedge clk);
        chk("abort_sa_c", {31'd0, sa_w[2]}, 32'd1);
        @(posedge clk);
        model_edge();
        #1;
        idle();
        step();
        chk("abort_sc_c", sc_w[2], 32'd4);
        chk("abort_fc_c", fc_w[2], 32'd2);

        // Reset in the first STALL cycle abandons the stall.
        lu_rs2(5'd4);
        step();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("rstst_sc_c", sc_w[2], 32'd0);
        chk("rstst_sa_c", {31'd0, sa_w[2]}, 32'd0);

        // 17 redirects wrap a 4-bit flush counter to 1.
        NextPCSrc = 1'b1;
        repeat (17) step();
        idle();
        step();
        chk("wrap_fc_b", fc_w[1], 32'd1);

        // Continuous hazard: back-to-back stalls with no gap.
        lu_rs2(5'd12);
        repeat (8) step();
        idle();
        repeat (3) step();

        // Randomized traffic with a small register range to provoke matches.
        repeat (400) begin
            rst        = ($urandom_range(0, 49) == 0);
            ex_load    = ($urandom_range(0, 1) == 1);
            ex_rd      = 5'($urandom_range(0, 3));
            id_rs1     = 5'($urandom_range(0, 3));
            id_rs2     = 5'($urandom_range(0, 3));
            id_use_rs1 = ($urandom_range(0, 1) == 1);
            id_use_rs2 = ($urandom_range(0, 1) == 1);
            NextPCSrc  = ($urandom_range(0, 9) == 0);
            step();
        end
        rst = 1'b0; idle();
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller that drives the stall/bubble and flush controls consumed by the IF/ID and ID/EX pipeline registers. It decides when the ID/EX register must capture a bubble via `hazard_detection`, freezes the PC and IF/ID on a load-use hazard, and squashes the IF/ID instruction on a taken branch or jump. A small state machine stretches load-use stalls to a configurable data-memory latency. Two event counters expose stall and flush activity for performance measurement.

## Interface

Parameters:
- `LOAD_STALL_CYCLES`, default 1: bubble cycles inserted per load-use hazard; legal range 1..3.
- `CNT_W`, default 32: width of the performance counters.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `id_rs1`  in  5  rs1 of the instruction in ID.
- `id_rs2`  in  5  rs2 of the instruction in ID.
- `id_use_rs1`  in  1  ID instruction reads rs1.
- `id_use_rs2`  in  1  ID instruction reads rs2.
- `ex_rd`  in  5  rd of the instruction in EX (ID/EX `rd_out`).
- `ex_load`  in  1  EX instruction is a load (ID/EX `load_out`).
- `NextPCSrc`  in  1  taken branch/jump resolved in EX this cycle.
- `hazard_detection`  out  1  ID/EX captures a bubble this cycle.
- `pc_write`  out  1  PC may update (0 = hold).
- `ifid_write`  out  1  IF/ID may update (0 = hold).
- `ifid_flush`  out  1  IF/ID loads a NOP this cycle.
- `stall_active`  out  1  FSM is in STALL.
- `stall_count`  out  CNT_W  total cycles with `hazard_detection`=1.
- `flush_count`  out  CNT_W  total cycles with `NextPCSrc`=1.

## Operation

- Load-use term: LU = `ex_load` & (`ex_rd` != 0) & ((`id_use_rs1` & `id_rs1`==`ex_rd`) | (`id_use_rs2` & `id_rs2`==`ex_rd`)).
- FSM states: RUN, STALL. Internal down-counter `cnt`, 2 bits.
- RUN, `NextPCSrc`=1: `ifid_flush`=1, `pc_write`=1, `ifid_write`=1, `hazard_detection`=0. Redirect has priority and LU is ignored, because the ID instruction is wrong-path. The ID/EX register flushes itself on `NextPCSrc`. Stay in RUN.
- RUN, LU=1, `NextPCSrc`=0: `hazard_detection`=1, `pc_write`=0, `ifid_write`=0, `ifid_flush`=0.
  - If `LOAD_STALL_CYCLES`>1, go to STALL with `cnt`=`LOAD_STALL_CYCLES`-1.
  - Otherwise stay in RUN.
- RUN, otherwise: `hazard_detection`=0, `pc_write`=1, `ifid_write`=1, `ifid_flush`=0.
- STALL, `NextPCSrc`=0: same outputs as the LU case, independent of LU and the other inputs. Decrement `cnt`; when `cnt`==1 at the clock edge, return to RUN.
- STALL, `NextPCSrc`=1: abort the stall and use the RUN redirect outputs. Next state RUN, `cnt`=0.
- `stall_active` = (state==STALL).
- Counters increment by 1 on each clock edge where the condition holds. They wrap modulo 2^CNT_W and are never saturated.
- `rst`=1: at the edge, state←RUN, `cnt`←0, both counters←0. While `rst` is high, outputs are forced regardless of inputs: `hazard_detection`=0, `pc_write`=1, `ifid_write`=1, `ifid_flush`=0. A reset mid-STALL abandons the stall.

## Timing

- Control outputs are combinational from the current inputs and state, with zero-cycle latency. They must settle within the cycle so the IF/ID and ID/EX registers sample them at the next edge.
- State, `cnt`, and the counters are registered; `stall_active` and the counter outputs are register outputs.
- Total bubbles per isolated load-use hazard = `LOAD_STALL_CYCLES`.
- PC/IF/ID hold duration is the same as the bubble count.
- A dependent instruction issues to EX on the cycle after the last bubble.
- Back-to-back hazards: a new LU seen in RUN on the cycle immediately after STALL exits starts a fresh stall with no gap.
- `NextPCSrc` and LU in the same cycle: only the flush is counted; `stall_count` is unchanged.

## Test plan

- Reset: hold `rst`=1 for 2 cycles with `ex_load`=1, `ex_rd`=5, `id_rs1`=5, `id_use_rs1`=1 → `hazard_detection`=0, `pc_write`=1, both counters 0, `stall_active`=0.
- Single load-use, `LOAD_STALL_CYCLES`=1: `ex_load`=1, `ex_rd`=7, `id_rs2`=7, `id_use_rs2`=1 for one cycle → one cycle with `hazard_detection`=1 and `pc_write`=`ifid_write`=0; `stall_count`=1 afterwards. Repeat with `ex_rd`=0 → no stall.
- Multi-cycle, `LOAD_STALL_CYCLES`=3: LU pulse for one cycle, then inputs idle → `hazard_detection`=1 for exactly 3 consecutive cycles, `stall_active`=1 for cycles 2–3, `stall_count`=3.
- Redirect priority: LU and `NextPCSrc`=1 in the same cycle → `ifid_flush`=1, `hazard_detection`=0, `pc_write`=1; `flush_count`+1, `stall_count` unchanged.
- Abort, `LOAD_STALL_CYCLES`=3: LU, then `NextPCSrc`=1 in the first STALL cycle → stall ends that cycle, state RUN next, `stall_count`=1, `flush_count`=1. Also apply `rst` in the first STALL cycle → state RUN and counters 0 after the edge.
- Wrap, `CNT_W`=4: 17 taken-branch cycles → `flush_count`=1.
